// File: rtl/wt_mem_arb_pkg.sv
// rtl/wt_mem_arb_pkg.sv - shared types and helpers for the WT memory request arbiter
package wt_mem_arb_pkg;

  localparam int DefNrPorts   = 3;
  localparam int DefAddrWidth = 64;
  localparam int DefDataWidth = 64;
  localparam int DefTidWidth  = 2;

  // Port-index field width; a single requester still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DefIdxW = idx_w(DefNrPorts);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                          we;
    logic [DefAddrWidth-1:0]       addr;
    logic [DefDataWidth-1:0]       wdata;
    logic [DefTidWidth+DefIdxW-1:0] tid;
  } mem_req_t;

  typedef struct packed {
    logic                          we;
    logic [DefTidWidth+DefIdxW-1:0] tid;
    logic [DefDataWidth-1:0]       rdata;
  } mem_rsp_t;

endpackage

// File: rtl/wt_mem_arb_rr_sel.sv
// rtl/wt_mem_arb_rr_sel.sv - masked round-robin selector: first eligible port at or after ptr
module wt_mem_arb_rr_sel
  import wt_mem_arb_pkg::*;
#(
  parameter int NrPorts = 3,
  parameter int IdxW    = idx_w(NrPorts)
) (
  input  logic [NrPorts-1:0] elig_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NrPorts-1:0] gnt_oh_o,
  output logic [IdxW-1:0]    gnt_idx_o,
  output logic               gnt_valid_o
);

  always_comb begin
    int c;
    c           = 0;
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int i = 0; i < NrPorts; i++) begin
      c = int'(ptr_i) + i;
      if (c >= NrPorts) c = c - NrPorts;
      if (!gnt_valid_o && elig_i[c[IdxW-1:0]]) begin
        gnt_valid_o            = 1'b1;
        gnt_oh_o[c[IdxW-1:0]]  = 1'b1;
        gnt_idx_o              = c[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/wt_mem_req_arbiter.sv
// rtl/wt_mem_req_arbiter.sv - shares the WT memory port between requesters
// Registered request slot, outstanding load/store bounds, TID response routing, drain FSM.
module wt_mem_req_arbiter
  import wt_mem_arb_pkg::*;
#(
  parameter int NrPorts      = DefNrPorts,
  parameter int AddrWidth    = DefAddrWidth,
  parameter int DataWidth    = DefDataWidth,
  parameter int TidWidth     = DefTidWidth,
  parameter int MaxOutStores = 7,
  parameter int MaxOutLoads  = 4,
  localparam int IdxW   = idx_w(NrPorts),
  localparam int StCntW = $clog2(MaxOutStores + 1),
  localparam int LdCntW = $clog2(MaxOutLoads + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NrPorts-1:0]            req_valid_i,
  output logic [NrPorts-1:0]            req_ready_o,
  input  logic [NrPorts-1:0]            req_we_i,
  input  logic [NrPorts*AddrWidth-1:0]  req_addr_i,
  input  logic [NrPorts*DataWidth-1:0]  req_wdata_i,
  input  logic [NrPorts*TidWidth-1:0]   req_tid_i,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic                          mem_req_we_o,
  output logic [AddrWidth-1:0]          mem_req_addr_o,
  output logic [DataWidth-1:0]          mem_req_wdata_o,
  output logic [TidWidth+IdxW-1:0]      mem_req_tid_o,
  input  logic                          mem_rsp_valid_i,
  input  logic                          mem_rsp_we_i,
  input  logic [TidWidth+IdxW-1:0]      mem_rsp_tid_i,
  input  logic [DataWidth-1:0]          mem_rsp_rdata_i,
  output logic [NrPorts-1:0]            rsp_valid_o,
  output logic [TidWidth-1:0]           rsp_tid_o,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  input  logic                          drain_i,
  output logic                          drained_o,
  output logic [StCntW-1:0]             out_stores_o
);

  arb_state_e               state_q, state_d;
  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_we_q, out_we_d;
  logic [AddrWidth-1:0]     out_addr_q, out_addr_d;
  logic [DataWidth-1:0]     out_wdata_q, out_wdata_d;
  logic [TidWidth+IdxW-1:0] out_tid_q, out_tid_d;
  logic [StCntW-1:0]        st_cnt_q, st_cnt_d;
  logic [LdCntW-1:0]        ld_cnt_q, ld_cnt_d;
  logic                     drained_q, drained_d;

  logic [NrPorts-1:0]       elig, sel_oh;
  logic [IdxW-1:0]          sel_idx, rsp_idx;
  logic                     sel_valid, grant, win_we, st_dec, ld_dec, quiet_next;
  logic [AddrWidth-1:0]     win_addr;
  logic [DataWidth-1:0]     win_wdata;
  logic [TidWidth-1:0]      win_tid;

  wt_mem_arb_rr_sel #(.NrPorts(NrPorts), .IdxW(IdxW)) u_rr_sel (
    .elig_i      (elig),
    .ptr_i       (ptr_q),
    .gnt_oh_o    (sel_oh),
    .gnt_idx_o   (sel_idx),
    .gnt_valid_o (sel_valid)
  );

  assign rsp_idx = mem_rsp_tid_i[TidWidth +: IdxW];

  always_comb begin
    for (int p = 0; p < NrPorts; p++) begin
      elig[p] = req_valid_i[p] && (state_q == RUN) &&
                (req_we_i[p] ? (st_cnt_q != StCntW'(MaxOutStores))
                             : (ld_cnt_q != LdCntW'(MaxOutLoads)));
    end

    // The slot can be refilled in the same cycle the downstream takes it.
    grant       = sel_valid && (!out_valid_q || mem_req_ready_i) && !rst_i;
    req_ready_o = grant ? sel_oh : '0;

    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_tid   = '0;
    for (int p = 0; p < NrPorts; p++) begin
      if (sel_oh[p]) begin
        win_we    = req_we_i[p];
        win_addr  = req_addr_i[p*AddrWidth +: AddrWidth];
        win_wdata = req_wdata_i[p*DataWidth +: DataWidth];
        win_tid   = req_tid_i[p*TidWidth +: TidWidth];
      end
    end

    out_valid_d = out_valid_q;
    out_we_d    = out_we_q;
    out_addr_d  = out_addr_q;
    out_wdata_d = out_wdata_q;
    out_tid_d   = out_tid_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_we_d    = win_we;
      out_addr_d  = win_addr;
      out_wdata_d = win_wdata;
      out_tid_d   = {sel_idx, win_tid};
      ptr_d       = (sel_idx == IdxW'(NrPorts - 1)) ? '0 : sel_idx + 1'b1;
    end else if (mem_req_ready_i) begin
      out_valid_d = 1'b0;
    end

    // Stray responses at zero count are ignored so the counters never wrap.
    st_dec   = mem_rsp_valid_i && mem_rsp_we_i && (st_cnt_q != '0);
    ld_dec   = mem_rsp_valid_i && !mem_rsp_we_i && (ld_cnt_q != '0);
    st_cnt_d = st_cnt_q + StCntW'(grant && win_we) - StCntW'(st_dec);
    ld_cnt_d = ld_cnt_q + LdCntW'(grant && !win_we) - LdCntW'(ld_dec);

    for (int p = 0; p < NrPorts; p++) begin
      rsp_valid_o[p] = mem_rsp_valid_i && (rsp_idx == IdxW'(p));
    end
    rsp_tid_o   = mem_rsp_tid_i[TidWidth-1:0];
    rsp_rdata_o = mem_rsp_rdata_i;

    quiet_next = !out_valid_d && (st_cnt_d == '0) && (ld_cnt_d == '0);
    state_d    = state_q;
    case (state_q)
      RUN:     if (drain_i) state_d = DRAIN;
      DRAIN:   if (!drain_i) state_d = RUN;
               else if (quiet_next) state_d = DONE;
      DONE:    if (!drain_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    drained_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      out_tid_q   <= '0;
      st_cnt_q    <= '0;
      ld_cnt_q    <= '0;
      drained_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_we_q    <= out_we_d;
      out_addr_q  <= out_addr_d;
      out_wdata_q <= out_wdata_d;
      out_tid_q   <= out_tid_d;
      st_cnt_q    <= st_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      drained_q   <= drained_d;
    end
  end

  assign mem_req_valid_o = out_valid_q;
  assign mem_req_we_o    = out_we_q;
  assign mem_req_addr_o  = out_addr_q;
  assign mem_req_wdata_o = out_wdata_q;
  assign mem_req_tid_o   = out_tid_q;
  assign drained_o       = drained_q;
  assign out_stores_o    = st_cnt_q;

  a_store_ack_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_rsp_valid_i && mem_rsp_we_i) |-> (st_cnt_q != '0));
  a_load_rsp_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_rsp_valid_i && !mem_rsp_we_i) |-> (ld_cnt_q != '0));
  a_rsp_port_range: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rsp_valid_i |-> (int'(rsp_idx) < NrPorts));

endmodule
